// File: rtl/buf_col_sel_counter.sv
// Column-select register for the line-buffer muxes: direct load, stepped sweeps
// (single-shot or continuous wrap) and event pulses toward the buffer controller.
module buf_col_sel_counter #(
    parameter int SEL_W     = 2,
    parameter int NUM_COLS  = 3,
    parameter int START_COL = 0
) (
    input  logic                CLK,
    input  logic                RST_ASYNC_N,
    input  logic                CLEAR,
    input  logic                LOAD_EN,
    input  logic [SEL_W-1:0]    LOAD_VAL,
    input  logic                START,
    input  logic                STOP,
    input  logic                STEP_EN,
    input  logic                WRAP_MODE,
    output logic [SEL_W-1:0]    SEL_OUT,
    output logic [NUM_COLS-1:0] SEL_ONEHOT,
    output logic                BUSY,
    output logic                WRAP_PULSE,
    output logic                DONE,
    output logic                LOAD_ERR
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0]    LAST_SEL  = SEL_W'(NUM_COLS - 1);
    localparam logic [SEL_W-1:0]    START_SEL = SEL_W'(START_COL);
    localparam logic [NUM_COLS-1:0] ONE_HOT0  = NUM_COLS'(1);

    state_t                r_state;
    state_t                w_stateNext;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      w_selNext;
    logic [NUM_COLS-1:0]   r_oneHot;
    logic                  r_wrapPulse;
    logic                  r_done;
    logic                  r_loadErr;
    logic                  w_wrap;
    logic                  w_done;
    logic                  w_loadErr;

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            r_state     <= IDLE;
            r_sel       <= START_SEL;
            r_oneHot    <= ONE_HOT0 << START_SEL;
            r_wrapPulse <= 1'b0;
            r_done      <= 1'b0;
            r_loadErr   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_sel       <= w_selNext;
            r_oneHot    <= ONE_HOT0 << w_selNext;
            r_wrapPulse <= w_wrap;
            r_done      <= w_done;
            r_loadErr   <= w_loadErr;
        end
    end

    // Priority CLEAR > STOP > LOAD/START > STEP_EN; STOP only has meaning in SWEEP.
    always_comb begin
        w_stateNext = r_state;
        w_selNext   = r_sel;
        w_wrap      = 1'b0;
        w_done      = 1'b0;
        w_loadErr   = 1'b0;
        if (CLEAR) begin
            w_stateNext = IDLE;
            w_selNext   = START_SEL;
        end else if (r_state == SWEEP) begin
            if (STOP) begin
                w_stateNext = IDLE;
            end else begin
                w_loadErr = LOAD_EN;
                if (STEP_EN) begin
                    if (r_sel == LAST_SEL) begin
                        w_selNext = '0;
                        w_wrap    = 1'b1;
                        if (!WRAP_MODE) begin
                            w_done      = 1'b1;
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_selNext = r_sel + 1'b1;
                    end
                end
            end
        end else begin
            if (LOAD_EN) begin
                if (LOAD_VAL <= LAST_SEL) begin
                    w_selNext = LOAD_VAL;
                end else begin
                    w_loadErr = 1'b1;
                end
            end
            if (START) begin
                w_stateNext = SWEEP;
            end
        end
    end

    assign SEL_OUT    = r_sel;
    assign SEL_ONEHOT = r_oneHot;
    assign BUSY       = (r_state == SWEEP);
    assign WRAP_PULSE = r_wrapPulse;
    assign DONE       = r_done;
    assign LOAD_ERR   = r_loadErr;

endmodule

// File: tb/tb_buf_col_sel_counter.sv
// Bench for buf_col_sel_counter: default and (3,5,2) instances share stimulus and
// are compared each cycle against a column-arithmetic reference model.
module tb_buf_col_sel_counter;

    logic       clk = 1'b0;
    logic       rstN;
    logic       clear, loadEn, start, stop, stepEn, wrapMode;
    logic [2:0] loadVal;

    logic [1:0] sel1;
    logic [2:0] hot1;
    logic       busy1, wrap1, done1, err1;
    logic [2:0] sel2;
    logic [4:0] hot2;
    logic       busy2, wrap2, done2, err2;

    int checks = 0;
    int errors = 0;
    int wrapCnt1, doneCnt1;

    int nCols[2] = '{3, 5};
    int sCol[2]  = '{0, 2};
    int mSel[2];
    bit mBusy[2], mWrap[2], mDone[2], mErr[2];

    always #5 clk = ~clk;

    buf_col_sel_counter dut1 (
        .CLK(clk), .RST_ASYNC_N(rstN), .CLEAR(clear), .LOAD_EN(loadEn),
        .LOAD_VAL(loadVal[1:0]), .START(start), .STOP(stop), .STEP_EN(stepEn),
        .WRAP_MODE(wrapMode), .SEL_OUT(sel1), .SEL_ONEHOT(hot1), .BUSY(busy1),
        .WRAP_PULSE(wrap1), .DONE(done1), .LOAD_ERR(err1)
    );

    buf_col_sel_counter #(.SEL_W(3), .NUM_COLS(5), .START_COL(2)) dut2 (
        .CLK(clk), .RST_ASYNC_N(rstN), .CLEAR(clear), .LOAD_EN(loadEn),
        .LOAD_VAL(loadVal), .START(start), .STOP(stop), .STEP_EN(stepEn),
        .WRAP_MODE(wrapMode), .SEL_OUT(sel2), .SEL_ONEHOT(hot2), .BUSY(busy2),
        .WRAP_PULSE(wrap2), .DONE(done2), .LOAD_ERR(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mSel[k]  = sCol[k];
            mBusy[k] = 0;
            mWrap[k] = 0;
            mDone[k] = 0;
            mErr[k]  = 0;
        end
    endtask

    // One clock edge of the column-select rules, applied to each configuration.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            int lv = (k == 0) ? int'(loadVal) % 4 : int'(loadVal);
            int n  = nCols[k];
            mWrap[k] = 0;
            mDone[k] = 0;
            mErr[k]  = 0;
            if (clear) begin
                mSel[k]  = sCol[k];
                mBusy[k] = 0;
            end else if (mBusy[k]) begin
                if (stop) begin
                    mBusy[k] = 0;
                end else begin
                    mErr[k] = loadEn;
                    if (stepEn) begin
                        mWrap[k] = (mSel[k] + 1 == n);
                        mSel[k]  = (mSel[k] + 1) % n;
                        if (mWrap[k] && !wrapMode) begin
                            mDone[k] = 1;
                            mBusy[k] = 0;
                        end
                    end
                end
            end else begin
                if (loadEn && lv < n) mSel[k] = lv;
                if (loadEn && lv >= n) mErr[k] = 1;
                if (start) mBusy[k] = 1;
            end
        end
    endtask

    task automatic checkOutput();
        check("d1.sel",  32'(sel1),  32'(mSel[0]));
        check("d1.hot",  32'(hot1),  32'(1) << mSel[0]);
        check("d1.busy", 32'(busy1), 32'(mBusy[0]));
        check("d1.wrap", 32'(wrap1), 32'(mWrap[0]));
        check("d1.done", 32'(done1), 32'(mDone[0]));
        check("d1.err",  32'(err1),  32'(mErr[0]));
        check("d2.sel",  32'(sel2),  32'(mSel[1]));
        check("d2.hot",  32'(hot2),  32'(1) << mSel[1]);
        check("d2.busy", 32'(busy2), 32'(mBusy[1]));
        check("d2.wrap", 32'(wrap2), 32'(mWrap[1]));
        check("d2.done", 32'(done2), 32'(mDone[1]));
        check("d2.err",  32'(err2),  32'(mErr[1]));
    endtask

    // Called at a falling edge: drive, clock once, then check at the next falling edge.
    task automatic applyStimulus(input bit c, input bit le, input logic [2:0] lv,
                                 input bit st, input bit sp, input bit se, input bit wm);
        clear    = c;
        loadEn   = le;
        loadVal  = lv;
        start    = st;
        stop     = sp;
        stepEn   = se;
        wrapMode = wm;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        if (wrap1) wrapCnt1++;
        if (done1) doneCnt1++;
        checkOutput();
    endtask

    task automatic asyncReset();
        applyStimulus(0, 0, 0, 0, 0, 0, wrapMode);
        #1;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput();
        #1;
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, wrapMode);
    endtask

    initial begin
        rstN = 1'b0;
        {clear, loadEn, start, stop, stepEn, wrapMode} = '0;
        loadVal = '0;
        modelReset();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        checkOutput();
        check("reset.sel1", 32'(sel1), 32'd0);
        check("reset.hot1", 32'(hot1), 32'b001);
        check("reset.sel2", 32'(sel2), 32'd2);
        check("reset.hot2", 32'(hot2), 32'b00100);

        applyStimulus(0, 1, 3'd2, 0, 0, 0, 0);
        check("load2.sel1", 32'(sel1), 32'd2);
        check("load2.hot1", 32'(hot1), 32'b100);

        applyStimulus(0, 1, 3'd3, 0, 0, 0, 0);
        check("badload.sel1", 32'(sel1), 32'd2);
        check("badload.err1", 32'(err1), 32'd1);
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
        check("badload.errlow", 32'(err1), 32'd0);

        // Single sweep from 0 on the default instance, 2 on the wide one.
        applyStimulus(1, 0, 3'd0, 0, 0, 0, 0);
        applyStimulus(0, 0, 3'd0, 1, 0, 0, 0);
        check("sweep.busy", 32'(busy1), 32'd1);
        applyStimulus(0, 1, 3'd1, 0, 0, 0, 0);
        check("sweepload.err1", 32'(err1), 32'd1);
        check("sweepload.sel1", 32'(sel1), 32'd0);
        applyStimulus(0, 0, 3'd0, 0, 0, 1, 0);
        check("single.s1", 32'(sel1), 32'd1);
        applyStimulus(0, 0, 3'd0, 0, 0, 1, 0);
        check("single.s2", 32'(sel1), 32'd2);
        check("single.d2s", 32'(sel2), 32'd4);
        applyStimulus(0, 0, 3'd0, 0, 0, 1, 0);
        check("single.s3", 32'(sel1), 32'd0);
        check("single.done", 32'(done1), 32'd1);
        check("single.wrap", 32'(wrap1), 32'd1);
        check("single.busy", 32'(busy1), 32'd0);
        check("single.d2wrap", 32'(sel2), 32'd0);

        // Continuous wrap with a two-cycle stall.
        applyStimulus(1, 0, 3'd0, 0, 0, 0, 1);
        applyStimulus(0, 0, 3'd0, 1, 0, 0, 1);
        wrapCnt1 = 0;
        doneCnt1 = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 3'd0, 0, 0, (i == 3 || i == 4) ? 1'b0 : 1'b1, 1);
        end
        check("cont.sel", 32'(sel1), 32'd1);
        check("cont.wraps", 32'(wrapCnt1), 32'd2);
        check("cont.dones", 32'(doneCnt1), 32'd0);
        check("cont.busy", 32'(busy1), 32'd1);

        applyStimulus(0, 0, 3'd0, 0, 1, 1, 1);
        check("stopstep.sel", 32'(sel1), 32'd1);
        check("stopstep.busy", 32'(busy1), 32'd0);
        applyStimulus(1, 1, 3'd2, 1, 0, 0, 1);
        check("clrprio.sel", 32'(sel1), 32'd0);
        check("clrprio.busy", 32'(busy1), 32'd0);
        check("clrprio.err", 32'(err1), 32'd0);
        applyStimulus(0, 1, 3'd1, 1, 0, 0, 1);
        check("loadstart.sel", 32'(sel1), 32'd1);
        check("loadstart.busy", 32'(busy1), 32'd1);
        applyStimulus(0, 0, 3'd0, 0, 0, 1, 1);
        check("prereset.sel", 32'(sel1), 32'd2);

        asyncReset();
        check("postreset.done", 32'(done1), 32'd0);
        check("postreset.sel2", 32'(sel2), 32'd2);

        for (int i = 0; i < 400; i++) begin
            bit c, le, st, sp, se, wm;
            logic [2:0] lv;
            c  = ($urandom_range(0, 19) == 0);
            le = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 14) == 0);
            se = $urandom_range(0, 1) == 1;
            wm = ($urandom_range(0, 19) == 0) ? ~wrapMode : wrapMode;
            lv = 3'($urandom_range(0, 7));
            if (st && le) lv = 3'($urandom_range(0, 2));
            if (i % 60 == 59) asyncReset();
            else applyStimulus(c, le, lv, st, sp, se, wm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
